draw_cmd_encoder: RTL

Producer side of the 32-bit draw-command FIFO. It accepts high-level draw requests over a valid/ready handshake and serializes them into FIFO command words (`cmd`/`cmd_vld`). These are the exact word formats the superpixel, rectangle and character drawers decode. It sits between game/UI logic and the command FIFO, throttled by the FIFO's `prefull` flag, and also expands strings into per-character command pairs.

---
 rtl/draw_cmd_encoder_if.sv | 42 ++++
 rtl/draw_cmd_encoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_cmd_encoder_if.sv
// Draw-request handshake, string-lookup side channel and FIFO command port
// shared by the request producers, the command encoder and the command FIFO.
interface draw_cmd_encoder_if #(
  parameter int H_PHY_WIDTH    = 10,
  parameter int V_PHY_WIDTH    = 9,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int STR_LEN_WIDTH  = 5
);
  logic                      req_vld;
  logic                      req_rdy;
  logic [2:0]                req_op;
  logic [H_PHY_WIDTH-1:0]    req_x0;
  logic [V_PHY_WIDTH-1:0]    req_y0;
  logic [H_PHY_WIDTH-1:0]    req_x1;
  logic [V_PHY_WIDTH-1:0]    req_y1;
  logic [COLOR_ID_WIDTH-1:0] req_fg;
  logic [COLOR_ID_WIDTH-1:0] req_bg;
  logic [7:0]                req_code;
  logic [3:0]                req_size;
  logic [STR_LEN_WIDTH-1:0]  req_len;
  logic [STR_LEN_WIDTH-1:0]  str_idx;
  logic [7:0]                str_code;
  logic                      enb;
  logic [31:0]               cmd;
  logic                      cmd_vld;
  logic                      busy;
  logic                      err;

  // Request producer / string table / FIFO side
  modport master (
    output req_vld, req_op, req_x0, req_y0, req_x1, req_y1,
           req_fg, req_bg, req_code, req_size, req_len, str_code, enb,
    input  req_rdy, str_idx, cmd, cmd_vld, busy, err
  );

  // Encoder side
  modport slave (
    input  req_vld, req_op, req_x0, req_y0, req_x1, req_y1,
           req_fg, req_bg, req_code, req_size, req_len, str_code, enb,
    output req_rdy, str_idx, cmd, cmd_vld, busy, err
  );
endinterface

// File: rtl/draw_cmd_encoder.sv
// Draw-command encoder: turns high-level draw requests into 32-bit command
// FIFO words for the superpixel, rectangle and character drawers, and expands
// strings into per-character word pairs, throttled by the FIFO room flag.
module draw_cmd_encoder #(
  parameter int H_LOGIC_WIDTH  = 5,
  parameter int V_LOGIC_WIDTH  = 5,
  parameter int H_PHY_WIDTH    = 10,
  parameter int V_PHY_WIDTH    = 9,
  parameter int H_PHY_MAX      = 639,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int STR_LEN_WIDTH  = 5
) (
  input logic               clk,
  input logic               rst,
  draw_cmd_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    WORD_A = 2'd2,
    WORD_B = 2'd3
  } state_t;

  localparam logic [2:0] OP_SPIXEL = 3'd0;
  localparam logic [2:0] OP_SRECT  = 3'd1;
  localparam logic [2:0] OP_PRECT  = 3'd2;
  localparam logic [2:0] OP_CHAR   = 3'd3;
  localparam logic [2:0] OP_STRING = 3'd4;

  localparam logic [3:0] CODE_SPIXEL = 4'h0;
  localparam logic [3:0] CODE_SRECT  = 4'h1;
  localparam logic [3:0] CODE_PRECT  = 4'h9;
  localparam logic [3:0] CODE_CHAR   = 4'hA;

  // Right-most usable column, widened by one bit so the fit test cannot wrap
  localparam logic [H_PHY_WIDTH:0] X_LIMIT = (H_PHY_WIDTH + 1)'(H_PHY_MAX);

  state_t                    state_r;
  logic [2:0]                op_r;
  logic [H_PHY_WIDTH-1:0]    x0_r;
  logic [V_PHY_WIDTH-1:0]    y0_r;
  logic [H_PHY_WIDTH-1:0]    x1_r;
  logic [V_PHY_WIDTH-1:0]    y1_r;
  logic [COLOR_ID_WIDTH-1:0] fg_r;
  logic [COLOR_ID_WIDTH-1:0] bg_r;
  logic [7:0]                code_r;
  logic [3:0]                size_r;
  logic [STR_LEN_WIDTH-1:0]  len_r;
  logic [STR_LEN_WIDTH-1:0]  idx_r;
  logic [31:0]               cmd_r;
  logic                      cmd_vld_r;
  logic                      err_r;

  logic [31:0]               word_a_s;
  logic [31:0]               word_b_s;
  logic [H_PHY_WIDTH-1:0]    x_step_s;
  logic [H_PHY_WIDTH:0]      char_end_s;
  logic                      char_fits_s;
  logic                      more_chars_s;

  function automatic logic [31:0] word_spixel(input logic [H_LOGIC_WIDTH-1:0]  x,
                                              input logic [V_LOGIC_WIDTH-1:0]  y,
                                              input logic [COLOR_ID_WIDTH-1:0] fg);
    return {CODE_SPIXEL, x, y, fg, 10'd0};
  endfunction

  function automatic logic [31:0] word_srect(input logic [H_LOGIC_WIDTH-1:0]  x0,
                                             input logic [V_LOGIC_WIDTH-1:0]  y0,
                                             input logic [H_LOGIC_WIDTH-1:0]  x1,
                                             input logic [V_LOGIC_WIDTH-1:0]  y1,
                                             input logic [COLOR_ID_WIDTH-1:0] fg);
    return {CODE_SRECT, x0, y0, x1, y1, fg};
  endfunction

  // Bit 0 tells the rectangle drawer whether this is the closing corner
  function automatic logic [31:0] word_prect(input logic [H_PHY_WIDTH-1:0]    x,
                                             input logic [V_PHY_WIDTH-1:0]    y,
                                             input logic [COLOR_ID_WIDTH-1:0] fg,
                                             input logic                      last);
    return {CODE_PRECT, x, y, fg, last};
  endfunction

  function automatic logic [31:0] word_char_a(input logic [COLOR_ID_WIDTH-1:0] fg,
                                              input logic [COLOR_ID_WIDTH-1:0] bg,
                                              input logic [3:0]                size);
    return {CODE_CHAR, fg, bg, size, 7'd0, 1'b0};
  endfunction

  function automatic logic [31:0] word_char_b(input logic [H_PHY_WIDTH-1:0] x,
                                              input logic [V_PHY_WIDTH-1:0] y,
                                              input logic [7:0]             code);
    return {CODE_CHAR, x, y, code, 1'b1};
  endfunction

  // Character cell width is 8 pixels per scale step; size_r is never 0
  assign x_step_s     = {{(H_PHY_WIDTH - 7){1'b0}}, size_r, 3'b000};
  assign char_end_s   = {1'b0, x0_r} + {1'b0, x_step_s} - {{H_PHY_WIDTH{1'b0}}, 1'b1};
  assign char_fits_s  = (char_end_s <= X_LIMIT);
  assign more_chars_s = (({1'b0, idx_r} + {{STR_LEN_WIDTH{1'b0}}, 1'b1}) < {1'b0, len_r});

  // Assemble the opening and closing word of the current request from its latched fields
  always_comb begin
    word_a_s = 32'd0;
    word_b_s = 32'd0;
    case (op_r)
      OP_SPIXEL: begin
        word_b_s = word_spixel(x0_r[H_LOGIC_WIDTH-1:0], y0_r[V_LOGIC_WIDTH-1:0], fg_r);
      end
      OP_SRECT: begin
        word_b_s = word_srect(x0_r[H_LOGIC_WIDTH-1:0], y0_r[V_LOGIC_WIDTH-1:0],
                              x1_r[H_LOGIC_WIDTH-1:0], y1_r[V_LOGIC_WIDTH-1:0], fg_r);
      end
      OP_PRECT: begin
        word_a_s = word_prect(x0_r, y0_r, fg_r, 1'b0);
        word_b_s = word_prect(x1_r, y1_r, fg_r, 1'b1);
      end
      OP_CHAR, OP_STRING: begin
        word_a_s = word_char_a(fg_r, bg_r, size_r);
        word_b_s = word_char_b(x0_r, y0_r, code_r);
      end
      default: begin
        word_a_s = 32'd0;
        word_b_s = 32'd0;
      end
    endcase
  end

  // Request sequencer: capture, string fetch, word emission gated by FIFO room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 3'd0;
      x0_r      <= '0;
      y0_r      <= '0;
      x1_r      <= '0;
      y1_r      <= '0;
      fg_r      <= '0;
      bg_r      <= '0;
      code_r    <= 8'd0;
      size_r    <= 4'd1;
      len_r     <= '0;
      idx_r     <= '0;
      cmd_r     <= 32'd0;
      cmd_vld_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      cmd_vld_r <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req_vld) begin
            op_r   <= bus.req_op;
            x0_r   <= bus.req_x0;
            y0_r   <= bus.req_y0;
            x1_r   <= bus.req_x1;
            y1_r   <= bus.req_y1;
            fg_r   <= bus.req_fg;
            bg_r   <= bus.req_bg;
            code_r <= bus.req_code;
            size_r <= (bus.req_size == 4'd0) ? 4'd1 : bus.req_size;
            len_r  <= bus.req_len;
            case (bus.req_op)
              OP_SPIXEL, OP_SRECT: state_r <= WORD_B;
              OP_PRECT, OP_CHAR:   state_r <= WORD_A;
              OP_STRING: begin
                idx_r   <= '0;
                state_r <= (bus.req_len != '0) ? FETCH : IDLE;
              end
              default: begin
                err_r   <= 1'b1;
                state_r <= IDLE;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH: begin
          // str_code now reflects str_idx; a character that would cross the
          // right edge ends the string and drops the rest of it
          code_r  <= bus.str_code;
          state_r <= char_fits_s ? WORD_A : IDLE;
        end
        WORD_A: begin
          if (bus.enb) begin
            cmd_r     <= word_a_s;
            cmd_vld_r <= 1'b1;
            state_r   <= WORD_B;
          end else begin
            state_r   <= WORD_A;
          end
        end
        WORD_B: begin
          if (bus.enb) begin
            cmd_r     <= word_b_s;
            cmd_vld_r <= 1'b1;
            if ((op_r == OP_STRING) && more_chars_s) begin
              x0_r    <= x0_r + x_step_s;
              idx_r   <= idx_r + {{(STR_LEN_WIDTH - 1){1'b0}}, 1'b1};
              state_r <= FETCH;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= WORD_B;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.req_rdy = (state_r == IDLE);
  assign bus.busy    = (state_r != IDLE);
  assign bus.str_idx = idx_r;
  assign bus.cmd     = cmd_r;
  assign bus.cmd_vld = cmd_vld_r;
  assign bus.err     = err_r;

endmodule
